switch_glyph_decoder: RTL and testbench

SWITCH_GLYPH_DECODER -- requirements
Module: switch_glyph_decoder

---
 rtl/font_pkg.sv | 18 +
 rtl/switch_debounce.sv | 118 +++++++++++
 rtl/switch_glyph_decoder.sv | 84 ++++++++
 tb/tb_switch_glyph_decoder.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/font_pkg.sv
// -----------------------------------------------------------------------------
// font_pkg
// Shared defaults and types for the switch-to-glyph offset path.
//   GLYPH_SHIFT_DEF : log2 of font bytes per glyph (0x200 bytes)
//   DIGIT_W_DEF     : bits per slide-switch group
//   db_state_t      : per-channel debounce FSM state
// -----------------------------------------------------------------------------
package font_pkg;

  localparam int GLYPH_SHIFT_DEF = 9;
  localparam int DIGIT_W_DEF     = 4;

  typedef enum logic [0:0] {
    DB_IDLE     = 1'b0,
    DB_COUNTING = 1'b1
  } db_state_t;

endpackage

// File: rtl/switch_debounce.sv
// -----------------------------------------------------------------------------
// switch_debounce
// One switch group: 2-flop synchroniser followed by a debounce FSM that only
// accepts a new level after it has been stable for DEBOUNCE_CYCLES samples.
// Ports:
//   clk_50MHz  : clock
//   rst        : asynchronous active-high reset
//   sw_raw     : raw asynchronous switch levels for this group
//   deb_value  : current debounced value (registered)
//   deb_done   : one-cycle strobe, high in the cycle a new value is accepted
//                (deb_value updates on the same clock edge)
// -----------------------------------------------------------------------------
module switch_debounce
  import font_pkg::*;
#(
  parameter int DIGIT_W         = DIGIT_W_DEF,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic               clk_50MHz,
  input  logic               rst,
  input  logic [DIGIT_W-1:0] sw_raw,
  output logic [DIGIT_W-1:0] deb_value,
  output logic               deb_done
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};

  logic [DIGIT_W-1:0] sync1_r;
  logic [DIGIT_W-1:0] sync2_r;
  logic [DIGIT_W-1:0] prev_r;
  logic [DIGIT_W-1:0] deb_r;
  logic [CNT_W-1:0]   cnt_r;
  db_state_t          state_r;

  db_state_t          state_nxt_s;
  logic [CNT_W-1:0]   cnt_nxt_s;
  logic               done_s;
  logic [DIGIT_W-1:0] deb_nxt_s;

  // State register: synchroniser, previous sample, counter, debounced value.
  always_ff @(posedge clk_50MHz or posedge rst) begin
    if (rst) begin
      sync1_r <= {DIGIT_W{1'b0}};
      sync2_r <= {DIGIT_W{1'b0}};
      prev_r  <= {DIGIT_W{1'b0}};
      deb_r   <= {DIGIT_W{1'b0}};
      cnt_r   <= CNT_ZERO;
      state_r <= DB_IDLE;
    end else begin
      sync1_r <= sw_raw;
      sync2_r <= sync1_r;
      prev_r  <= sync2_r;
      deb_r   <= deb_nxt_s;
      cnt_r   <= cnt_nxt_s;
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic: count consecutive identical samples that differ from
  // the debounced value; reaching the limit accepts and returns to IDLE.
  // The counter is cleared on acceptance, so it never exceeds CNT_LIMIT.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    done_s      = 1'b0;
    case (state_r)
      DB_IDLE: begin
        if (sync2_r != deb_r) begin
          state_nxt_s = DB_COUNTING;
          cnt_nxt_s   = CNT_ONE;
        end else begin
          state_nxt_s = DB_IDLE;
          cnt_nxt_s   = CNT_ZERO;
        end
      end
      DB_COUNTING: begin
        if (sync2_r == deb_r) begin
          state_nxt_s = DB_IDLE;
          cnt_nxt_s   = CNT_ZERO;
        end else if (sync2_r != prev_r) begin
          state_nxt_s = DB_COUNTING;
          cnt_nxt_s   = CNT_ONE;
        end else begin
          state_nxt_s = DB_COUNTING;
          cnt_nxt_s   = cnt_r + CNT_ONE;
        end
      end
      default: begin
        state_nxt_s = DB_IDLE;
        cnt_nxt_s   = CNT_ZERO;
      end
    endcase
    if ((state_nxt_s == DB_COUNTING) && (cnt_nxt_s == CNT_LIMIT)) begin
      done_s      = 1'b1;
      state_nxt_s = DB_IDLE;
      cnt_nxt_s   = CNT_ZERO;
    end else begin
      done_s      = 1'b0;
    end
  end

  // Output logic: debounced value takes the sample on acceptance.
  always_comb begin
    deb_nxt_s = deb_r;
    if (done_s) begin
      deb_nxt_s = sync2_r;
    end else begin
      deb_nxt_s = deb_r;
    end
  end

  assign deb_value = deb_r;
  assign deb_done  = done_s;

endmodule

// File: rtl/switch_glyph_decoder.sv
// -----------------------------------------------------------------------------
// switch_glyph_decoder
// Debounces CHANNELS slide-switch groups and converts each accepted value into
// a font glyph byte offset, committed only on the frame-boundary strobe so the
// glyph never changes mid-frame.
// Ports:
//   clk_50MHz      : clock
//   rst            : asynchronous active-high reset
//   switch_bus     : raw switches, channel n at [n*DIGIT_W +: DIGIT_W]
//   vsync_pulse    : one-cycle frame-boundary strobe (commit point)
//   offset         : committed glyph offset per channel (registered)
//   offset_update  : one-cycle pulse per channel, aligned with a new offset
//   change_pending : debounced value waiting for the next vsync_pulse
// -----------------------------------------------------------------------------
module switch_glyph_decoder
  import font_pkg::*;
#(
  parameter int CHANNELS        = 2,
  parameter int DIGIT_W         = DIGIT_W_DEF,
  parameter int GLYPH_SHIFT     = GLYPH_SHIFT_DEF,
  parameter int OFFSET_W        = DIGIT_W + GLYPH_SHIFT,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic                         clk_50MHz,
  input  logic                         rst,
  input  logic [CHANNELS*DIGIT_W-1:0]  switch_bus,
  input  logic                         vsync_pulse,
  output logic [CHANNELS*OFFSET_W-1:0] offset,
  output logic [CHANNELS-1:0]          offset_update,
  output logic [CHANNELS-1:0]          change_pending
);

  logic [DIGIT_W-1:0]  deb_value_s [CHANNELS];
  logic                deb_done_s  [CHANNELS];
  logic [OFFSET_W-1:0] glyph_off_s [CHANNELS];

  logic [CHANNELS*OFFSET_W-1:0] offset_r;
  logic [CHANNELS-1:0]          update_r;
  logic [CHANNELS-1:0]          pending_r;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    switch_debounce #(
      .DIGIT_W         (DIGIT_W),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk_50MHz (clk_50MHz),
      .rst       (rst),
      .sw_raw    (switch_bus[g*DIGIT_W +: DIGIT_W]),
      .deb_value (deb_value_s[g]),
      .deb_done  (deb_done_s[g])
    );

    // Zero-extend before shifting so the top digit bits are not lost.
    assign glyph_off_s[g] = OFFSET_W'(deb_value_s[g]) << GLYPH_SHIFT;
  end

  // Commit logic: a fresh acceptance always wins over vsync, so a value that
  // completes on the vsync cycle stays pending until the following frame.
  always_ff @(posedge clk_50MHz or posedge rst) begin
    if (rst) begin
      offset_r  <= {(CHANNELS*OFFSET_W){1'b0}};
      update_r  <= {CHANNELS{1'b0}};
      pending_r <= {CHANNELS{1'b0}};
    end else begin
      for (int ch = 0; ch < CHANNELS; ch++) begin
        if (deb_done_s[ch]) begin
          pending_r[ch] <= 1'b1;
          update_r[ch]  <= 1'b0;
        end else if (vsync_pulse && pending_r[ch]) begin
          offset_r[ch*OFFSET_W +: OFFSET_W] <= glyph_off_s[ch];
          update_r[ch]  <= 1'b1;
          pending_r[ch] <= 1'b0;
        end else begin
          update_r[ch]  <= 1'b0;
        end
      end
    end
  end

  assign offset         = offset_r;
  assign offset_update  = update_r;
  assign change_pending = pending_r;

endmodule

// File: tb/tb_switch_glyph_decoder.sv
// -----------------------------------------------------------------------------
// tb_switch_glyph_decoder
// Scoreboard bench: each vsync that should commit pushes the expected
// update mask and full offset bus; a monitor pops and compares whenever the
// DUT raises offset_update. Unexpected pulses are reported.
// -----------------------------------------------------------------------------
module tb_switch_glyph_decoder;

  localparam int CH = 2;
  localparam int DW = 4;
  localparam int OW = 13;

  typedef struct {
    logic [CH-1:0]    mask;
    logic [CH*OW-1:0] off;
  } exp_t;

  logic               clk_50MHz = 1'b0;
  logic               rst;
  logic [CH*DW-1:0]   switch_bus;
  logic               vsync_pulse;
  logic [CH*OW-1:0]   offset;
  logic [CH-1:0]      offset_update;
  logic [CH-1:0]      change_pending;

  exp_t sb_q [$];
  int   n_checks = 0;
  int   n_pass   = 0;

  switch_glyph_decoder #(
    .CHANNELS        (CH),
    .DEBOUNCE_CYCLES (4)
  ) dut (
    .clk_50MHz      (clk_50MHz),
    .rst            (rst),
    .switch_bus     (switch_bus),
    .vsync_pulse    (vsync_pulse),
    .offset         (offset),
    .offset_update  (offset_update),
    .change_pending (change_pending)
  );

  always #10 clk_50MHz = ~clk_50MHz;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk_50MHz);
  endtask

  task automatic pulse_vsync();
    vsync_pulse = 1'b1;
    @(negedge clk_50MHz);
    vsync_pulse = 1'b0;
  endtask

  task automatic push_exp(input logic [CH-1:0] m, input logic [OW-1:0] o1, input logic [OW-1:0] o0);
    exp_t e;
    e.mask = m;
    e.off  = {o1, o0};
    sb_q.push_back(e);
  endtask

  // Monitor: compare every offset_update pulse against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk_50MHz);
      #1;
      if (offset_update != '0) begin
        if (sb_q.size() == 0) begin
          check_val("spurious_update", 64'(offset_update), 64'd0);
        end else begin
          e = sb_q.pop_front();
          check_val("upd_mask", 64'(offset_update), 64'(e.mask));
          check_val("upd_offset", 64'(offset), 64'(e.off));
        end
      end
    end
  end

  initial begin
    int lat;
    rst         = 1'b1;
    switch_bus  = '0;
    vsync_pulse = 1'b0;
    tick(3);
    check_val("rst_offset", 64'(offset), 64'd0);
    check_val("rst_update", 64'(offset_update), 64'd0);
    check_val("rst_pending", 64'(change_pending), 64'd0);
    rst = 1'b0;
    tick(2);

    // ch0 0 -> 5: pending after 2 + 4 edges, commit 0x0A00
    switch_bus[3:0] = 4'h5;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk_50MHz);
      #1;
      if (change_pending[0]) begin
        lat = i;
        break;
      end
    end
    check_val("pend_latency", 64'(lat), 64'd6);
    check_val("pend_mask_s1", 64'(change_pending), 64'h1);
    @(negedge clk_50MHz);
    tick(4);
    push_exp(2'b01, 13'h0000, 13'h0A00);
    pulse_vsync();
    tick(2);
    check_val("pend_clr_s1", 64'(change_pending), 64'h0);
    check_val("offset_s1", 64'(offset), {38'd0, 13'h0000, 13'h0A00});

    // ch1 bounces 3 <-> 4 every 2 cycles: never accepted
    for (int k = 0; k < 10; k++) begin
      switch_bus[7:4] = (k % 2 == 1) ? 4'h4 : 4'h3;
      tick(2);
      check_val("bounce_pend", 64'(change_pending[1]), 64'd0);
    end
    switch_bus[7:4] = 4'h0;
    tick(8);
    check_val("bounce_pend_end", 64'(change_pending), 64'h0);
    pulse_vsync();
    tick(2);
    check_val("offset_no_commit", 64'(offset), {38'd0, 13'h0000, 13'h0A00});

    // ch0 -> F completes on the vsync cycle: deferred to the next vsync
    switch_bus[3:0] = 4'hF;
    tick(5);
    vsync_pulse = 1'b1;
    tick(1);
    vsync_pulse = 1'b0;
    check_val("pend_same_cycle", 64'(change_pending), 64'h1);
    check_val("offset_held", 64'(offset), {38'd0, 13'h0000, 13'h0A00});
    tick(2);
    push_exp(2'b01, 13'h0000, 13'h1E00);
    pulse_vsync();
    tick(3);

    // ch0 -> 2 then -> 7 before vsync: only 7 commits
    switch_bus[3:0] = 4'h2;
    tick(10);
    switch_bus[3:0] = 4'h7;
    tick(10);
    check_val("pend_overwrite", 64'(change_pending), 64'h1);
    push_exp(2'b01, 13'h0000, 13'h0E00);
    pulse_vsync();
    tick(3);

    // both channels at once: ch0=9, ch1=A
    switch_bus = {4'hA, 4'h9};
    tick(10);
    check_val("pend_both", 64'(change_pending), 64'h3);
    push_exp(2'b11, 13'h1400, 13'h1200);
    pulse_vsync();
    tick(3);

    // ch0 -> 4 -> 9: same as committed value still recommits
    switch_bus[3:0] = 4'h4;
    tick(10);
    switch_bus[3:0] = 4'h9;
    tick(10);
    check_val("pend_same_val", 64'(change_pending), 64'h1);
    push_exp(2'b01, 13'h1400, 13'h1200);
    pulse_vsync();
    tick(3);

    // reset while ch0 is counting
    switch_bus[3:0] = 4'h3;
    tick(4);
    rst = 1'b1;
    #1;
    check_val("rst_cnt_offset", 64'(offset), 64'd0);
    check_val("rst_cnt_pending", 64'(change_pending), 64'd0);
    tick(2);
    rst = 1'b0;
    tick(10);
    check_val("pend_after_rst", 64'(change_pending), 64'h3);
    push_exp(2'b11, 13'h1400, 13'h0600);
    pulse_vsync();

    // reset while the update pulse is high
    rst = 1'b1;
    #1;
    check_val("rst_upd_update", 64'(offset_update), 64'd0);
    check_val("rst_upd_offset", 64'(offset), 64'd0);
    tick(2);
    rst = 1'b0;
    tick(12);
    check_val("pend_after_rst2", 64'(change_pending), 64'h3);
    check_val("offset_after_rst2", 64'(offset), 64'd0);

    check_val("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
